// File: rtl/amiq_i2c_slave_rx.sv
// Write-only I2C target: address match, ACK, received bytes out through a 1-deep valid/ready register.
// Latency: pin edge -> filtered line 2+FILTER_LEN cycles; bus events act one cycle later.
// Backpressure: full register NACKs the byte and pulses overrun, or with AMIQ_I2C_SLAVE_STRETCH_EN holds SCL low until free.
`timescale 1ns/1ps
module amiq_i2c_slave_rx #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       sda_o,
  output logic       sda_o_en,
  output logic       scl_o,
  output logic       scl_o_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
  output logic       overrun,
  output logic       bus_busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0]         sync1, sync2, filt, filt_q;
  logic [1:0][CW-1:0] fcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      fcnt   <= '0;
    end else begin
      sync1  <= {sda_i, scl_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == CNT_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + CW'(1);
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_evt, stop_evt;
  assign scl_rise  =  filt[0] & ~filt_q[0];
  assign scl_fall  = ~filt[0] &  filt_q[0];
  assign start_evt =  filt[0] &  filt_q[0] & ~filt[1] &  filt_q[1];
  assign stop_evt  =  filt[0] &  filt_q[0] &  filt[1] & ~filt_q[1];

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic       first_flag;
  logic       scl_hold;
  logic       rx_free;
  logic       byte_ready;

  assign rx_free    = ~rx_valid | rx_ready;
  // A held (stretched) byte is retried every cycle until the register frees up.
  assign byte_ready = scl_hold | (scl_fall & (bit_cnt == 4'd8));
  assign scl_o_en   = scl_hold;
  assign scl_o      = ~scl_hold;

`ifndef AMIQ_I2C_SLAVE_STRETCH_EN
  assign scl_hold = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      first_flag <= 1'b0;
      sda_o      <= 1'b1;
      sda_o_en   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      overrun    <= 1'b0;
      bus_busy   <= 1'b0;
`ifdef AMIQ_I2C_SLAVE_STRETCH_EN
      scl_hold   <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (stop_evt) begin
        state    <= IDLE;
        sda_o    <= 1'b1;
        sda_o_en <= 1'b0;
        bus_busy <= 1'b0;
`ifdef AMIQ_I2C_SLAVE_STRETCH_EN
        scl_hold <= 1'b0;
`endif
      end else if (start_evt) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_o    <= 1'b1;
        sda_o_en <= 1'b0;
        bus_busy <= 1'b1;
`ifdef AMIQ_I2C_SLAVE_STRETCH_EN
        scl_hold <= 1'b0;
`endif
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], filt[1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shreg == {SLAVE_ADDR, 1'b0}) begin
                sda_o      <= 1'b0;
                sda_o_en   <= 1'b1;
                first_flag <= 1'b1;
                state      <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              sda_o    <= 1'b1;
              sda_o_en <= 1'b0;
              bit_cnt  <= '0;
              state    <= DATA;
            end
          end
          DATA: begin
            if (byte_ready) begin
              bit_cnt <= '0;
              if (rx_free) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                rx_first   <= first_flag;
                first_flag <= 1'b0;
                sda_o      <= 1'b0;
                sda_o_en   <= 1'b1;
                state      <= DATA_ACK;
`ifdef AMIQ_I2C_SLAVE_STRETCH_EN
                scl_hold   <= 1'b0;
`endif
              end else begin
`ifdef AMIQ_I2C_SLAVE_STRETCH_EN
                scl_hold <= 1'b1;
`else
                overrun  <= 1'b1;
                state    <= DATA_ACK;
`endif
              end
            end else if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], filt[1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: ;  // IDLE and IGNORE only leave on START/STOP
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amiq_i2c_slave_rx.sv
// Directed bench for amiq_i2c_slave_rx: bus master tasks on a wired-AND bus, vector table plus corner sequences.
`timescale 1ns/1ps
module tb_amiq_i2c_slave_rx;
  localparam int Q = 10;  // quarter SCL period in clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ready = 1'b0;
  logic       sda_i, scl_i, sda_o, sda_o_en, scl_o, scl_o_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, overrun, bus_busy;

  assign sda_i = m_sda & (sda_o_en ? sda_o : 1'b1);
  assign scl_i = m_scl & (scl_o_en ? scl_o : 1'b1);

  amiq_i2c_slave_rx #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clock(clock), .reset(reset), .sda_i(sda_i), .scl_i(scl_i),
    .sda_o(sda_o), .sda_o_en(sda_o_en), .scl_o(scl_o), .scl_o_en(scl_o_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_first(rx_first),
    .overrun(overrun), .bus_busy(bus_busy)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  logic [7:0] got_q[$];
  logic       got_first_q[$];
  int         ovr_cnt = 0;
  int         stretch_cyc = 0;
  int         stretch_total = 0;
  logic       drove = 1'b0;

  always begin
    @(negedge clock);
    #2;
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        got_q.push_back(rx_data);
        got_first_q.push_back(rx_first);
      end
      if (sda_o_en) drove = 1'b1;
      if (overrun) ovr_cnt++;
      if (scl_o_en) begin
        stretch_cyc++;
        stretch_total++;
      end
    end
  end

  task automatic clr_mon();
    got_q.delete();
    got_first_q.delete();
    ovr_cnt = 0;
    stretch_cyc = 0;
    drove = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_scl_high();
    int k = 0;
    while (!scl_i && k < 4000) begin
      @(negedge clock);
      k++;
    end
    if (!scl_i) begin
      n_total++;
      $display("FAIL scl_wait: SCL still low after %0d cycles, required released", k);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_cyc(Q);
    m_scl = 1'b1; wait_scl_high(); wait_cyc(Q);
    m_sda = 1'b0; wait_cyc(Q);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_cyc(Q);
    m_scl = 1'b1; wait_scl_high(); wait_cyc(Q);
    m_sda = 1'b1; wait_cyc(2 * Q);
  endtask

  task automatic send_bit(input logic b, input logic g_scl, input logic g_sda);
    m_sda = b; wait_cyc(Q);
    m_scl = 1'b1; wait_scl_high(); wait_cyc(Q);
    if (g_scl) begin m_scl = 1'b0; wait_cyc(2); m_scl = 1'b1; end
    if (g_sda) begin m_sda = 1'b0; wait_cyc(2); m_sda = 1'b1; end
    wait_cyc(Q);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic ack_slot(output logic ack);
    m_sda = 1'b1; wait_cyc(Q);
    m_scl = 1'b1; wait_scl_high(); wait_cyc(Q);
    ack = ~sda_i;
    wait_cyc(Q);
    m_scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int g_scl, input int g_sda, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == g_scl, i == g_sda);
    ack_slot(ack);
  endtask

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] data_b;
    logic       exp_aack;
    logic       exp_dack;
    int         exp_n;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic aack, dack;
    int   k;

    vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1, 8'h3C};
    vecs[1] = '{8'hA2, 8'h11, 1'b0, 1'b0, 0, 8'h00};
    vecs[2] = '{8'hA1, 8'hFF, 1'b0, 1'b0, 0, 8'h00};
    vecs[3] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1, 8'h00};
    vecs[4] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 1, 8'hFF};
    vecs[5] = '{8'h50, 8'hA0, 1'b0, 1'b0, 0, 8'h00};
    vecs[6] = '{8'hA0, 8'hA5, 1'b1, 1'b1, 1, 8'hA5};

    // Reset state
    wait_cyc(3);
    check("rst_sda_o", sda_o, 1);
    check("rst_sda_o_en", sda_o_en, 0);
    check("rst_scl_o", scl_o, 1);
    check("rst_scl_o_en", scl_o_en, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_first", rx_first, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bus_busy", bus_busy, 0);
    reset = 1'b0;
    wait_cyc(20);
    check("idle_bus_busy", bus_busy, 0);
    check("idle_sda_o_en", sda_o_en, 0);

    // Table of single-byte write transactions, register drained immediately
    rx_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      clr_mon();
      i2c_start();
      check($sformatf("v%0d_busy_after_start", v), bus_busy, 1);
      send_byte(vecs[v].addr_b, -1, -1, aack);
      check($sformatf("v%0d_addr_ack", v), aack, vecs[v].exp_aack);
      send_byte(vecs[v].data_b, -1, -1, dack);
      check($sformatf("v%0d_data_ack", v), dack, vecs[v].exp_dack);
      i2c_stop();
      wait_cyc(10);
      check($sformatf("v%0d_busy_after_stop", v), bus_busy, 0);
      check($sformatf("v%0d_sda_driven", v), drove, vecs[v].exp_aack);
      check($sformatf("v%0d_rx_count", v), got_q.size(), vecs[v].exp_n);
      if (vecs[v].exp_n == 1 && got_q.size() == 1) begin
        check($sformatf("v%0d_rx_data", v), got_q[0], vecs[v].exp_data);
        check($sformatf("v%0d_rx_first", v), got_first_q[0], 1);
      end
    end

    // Backpressure: two data bytes with the register never read
    clr_mon();
    rx_ready = 1'b0;
    i2c_start();
    send_byte(8'hA0, -1, -1, aack);
    check("bp_addr_ack", aack, 1);
    send_byte(8'h01, -1, -1, dack);
    check("bp_byte1_ack", dack, 1);
    check("bp_byte1_valid", rx_valid, 1);
`ifdef AMIQ_I2C_SLAVE_STRETCH_EN
    fork
      send_byte(8'h02, -1, -1, dack);
      begin
        k = 0;
        while (!scl_o_en && k < 2000) begin
          @(negedge clock);
          k++;
        end
        check("bp_stretch_on", scl_o_en, 1);
        wait_cyc(50);
        check("bp_scl_held_low", scl_i, 0);
        check("bp_held_data", rx_data, 8'h01);
        rx_ready = 1'b1;
      end
    join
    check("bp_byte2_ack", dack, 1);
    i2c_stop();
    wait_cyc(10);
    check("bp_scl_released", scl_o_en, 0);
    check("bp_overrun_cnt", ovr_cnt, 0);
    check("bp_rx_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("bp_rx0", got_q[0], 8'h01);
      check("bp_rx0_first", got_first_q[0], 1);
      check("bp_rx1", got_q[1], 8'h02);
      check("bp_rx1_first", got_first_q[1], 0);
    end
`else
    send_byte(8'h02, -1, -1, dack);
    check("bp_byte2_nack", dack, 0);
    i2c_stop();
    wait_cyc(10);
    check("bp_overrun_cnt", ovr_cnt, 1);
    check("bp_rx_data_kept", rx_data, 8'h01);
    check("bp_rx_valid_kept", rx_valid, 1);
    check("bp_rx_first_kept", rx_first, 1);
    rx_ready = 1'b1;
    wait_cyc(2);
    check("bp_drained", rx_valid, 0);
    check("bp_rx_count", got_q.size(), 1);
    if (got_q.size() == 1) check("bp_rx0", got_q[0], 8'h01);
`endif

    // Sub-filter glitches: 2-cycle SCL low and 2-cycle SDA low while SCL high
    clr_mon();
    rx_ready = 1'b1;
    i2c_start();
    send_byte(8'hA0, -1, -1, aack);
    send_byte(8'h5A, 5, 6, dack);
    check("gl_data_ack", dack, 1);
    check("gl_busy_mid", bus_busy, 1);
    i2c_stop();
    wait_cyc(10);
    check("gl_rx_count", got_q.size(), 1);
    if (got_q.size() == 1) check("gl_rx_data", got_q[0], 8'h5A);

    // Repeated START mid-byte returns to address phase
    clr_mon();
    i2c_start();
    send_byte(8'hA0, -1, -1, aack);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
    i2c_start();
    check("rs_busy", bus_busy, 1);
    send_byte(8'hA0, -1, -1, aack);
    check("rs_addr_ack", aack, 1);
    send_byte(8'h77, -1, -1, dack);
    check("rs_data_ack", dack, 1);
    i2c_stop();
    wait_cyc(10);
    check("rs_rx_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("rs_rx_data", got_q[0], 8'h77);
      check("rs_rx_first", got_first_q[0], 1);
    end

    // Asynchronous reset while the address ACK is driven
    clr_mon();
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h01) != 8'h00, 1'b0, 1'b0);
    m_sda = 1'b1;
    wait_cyc(2);
    check("ar_acking", sda_o_en, 1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("ar_sda_released", sda_o_en, 0);
    check("ar_sda_line", sda_i, 1);
    check("ar_busy_clear", bus_busy, 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(20);
    check("ar_rx_valid", rx_valid, 0);
    clr_mon();
    i2c_start();
    send_byte(8'hA0, -1, -1, aack);
    check("ar_addr_ack", aack, 1);
    send_byte(8'h55, -1, -1, dack);
    check("ar_data_ack", dack, 1);
    i2c_stop();
    wait_cyc(10);
    check("ar_rx_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("ar_rx_data", got_q[0], 8'h55);
      check("ar_rx_first", got_first_q[0], 1);
    end

`ifndef AMIQ_I2C_SLAVE_STRETCH_EN
    check("no_stretch_ever", stretch_total, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
